// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-stage access sequencer.
// Holds FSM state encoding, access-size codes, lane masks and alignment helpers.
package mem_pkg;

    localparam int WORD = 64;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    // Right-justified mask covering the bytes of one access.
    function automatic logic [WORD-1:0] lane_mask(input logic [1:0] size);
        logic [WORD-1:0] m;
        m = '1;
        unique case (size)
            SZ_B: m = 64'h0000_0000_0000_00FF;
            SZ_H: m = 64'h0000_0000_0000_FFFF;
            SZ_W: m = 64'h0000_0000_FFFF_FFFF;
            SZ_D: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m;
    endfunction

    // True when the byte offset is a multiple of the access size.
    function automatic logic is_aligned(input logic [2:0] off,
                                        input logic [1:0] size);
        logic ok;
        ok = 1'b1;
        unique case (size)
            SZ_B: ok = 1'b1;
            SZ_H: ok = (off[0] == 1'b0);
            SZ_W: ok = (off[1:0] == 2'b00);
            SZ_D: ok = (off == 3'b000);
        endcase
        return ok;
    endfunction

    // Forces the offset down to the natural alignment of the size.
    function automatic logic [2:0] align_off(input logic [2:0] off,
                                             input logic [1:0] size);
        logic [2:0] o;
        o = off;
        unique case (size)
            SZ_B: o = off;
            SZ_H: o = {off[2:1], 1'b0};
            SZ_W: o = {off[2], 2'b00};
            SZ_D: o = 3'b000;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane aligner: extracts and extends load data, merges store data.
// Ports: i_hold, i_wdata, i_off, i_size, i_signed -> o_ld_data, o_st_data.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [WORD-1:0] i_hold,
    input  logic [WORD-1:0] i_wdata,
    input  logic [2:0]      i_off,
    input  logic [1:0]      i_size,
    input  logic            i_signed,
    output logic [WORD-1:0] o_ld_data,
    output logic [WORD-1:0] o_st_data
);

    logic [5:0]      w_sh;
    logic [WORD-1:0] w_mask;
    logic [WORD-1:0] w_lane;

    assign w_sh   = {i_off, 3'b000};
    assign w_mask = lane_mask(i_size);
    assign w_lane = (i_hold >> w_sh) & w_mask;

    always_comb begin
        o_ld_data = w_lane;
        unique case (i_size)
            SZ_B: o_ld_data = {{56{i_signed & w_lane[7]}},  w_lane[7:0]};
            SZ_H: o_ld_data = {{48{i_signed & w_lane[15]}}, w_lane[15:0]};
            SZ_W: o_ld_data = {{32{i_signed & w_lane[31]}}, w_lane[31:0]};
            SZ_D: o_ld_data = w_lane;
        endcase
    end

    // A doubleword has an all-ones mask at offset 0, so this reduces to wdata.
    assign o_st_data = (i_hold & ~(w_mask << w_sh))
                     | ((i_wdata & w_mask) << w_sh);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access sequencer: one load/store at a time, RMW for sub-dword stores.
// Ports: req_* from MEM stage, rsp_* back, mem_* to data_memory. Option: MEM_ALIGN_CHECK_EN.
module mem_access_ctrl
    import mem_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [1:0]      req_size,
    input  logic            req_signed,
    input  logic [WORD-1:0] req_addr,
    input  logic [WORD-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [WORD-1:0] rsp_rdata,
    output logic            rsp_fault,
    output logic            mem_read,
    output logic            mem_write,
    output logic [WORD-1:0] mem_address,
    output logic [WORD-1:0] mem_write_data,
    input  logic [WORD-1:0] mem_read_data
);

    state_t          r_state;
    logic [WORD-1:0] r_addr;
    logic [2:0]      r_off;
    logic [1:0]      r_size;
    logic            r_signed;
    logic            r_write;
    logic            r_fault;
    logic [WORD-1:0] r_wdata;
    logic [WORD-1:0] r_hold;

    logic            w_fault_in;
    logic [2:0]      w_off_in;
    logic [WORD-1:0] w_ld_data;
    logic [WORD-1:0] w_st_data;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_fault_in = !is_aligned(req_addr[2:0], req_size);
    assign w_off_in   = req_addr[2:0];
`else
    assign w_fault_in = 1'b0;
    assign w_off_in   = align_off(req_addr[2:0], req_size);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_off    <= '0;
            r_size   <= SZ_B;
            r_signed <= 1'b0;
            r_write  <= 1'b0;
            r_fault  <= 1'b0;
            r_wdata  <= '0;
            r_hold   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr   <= {req_addr[WORD-1:3], 3'b000};
                        r_off    <= w_off_in;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_write  <= req_write;
                        r_fault  <= w_fault_in;
                        r_wdata  <= req_wdata;
                        if (w_fault_in)
                            r_state <= S_RESP;
                        else if (req_write && req_size == SZ_D)
                            r_state <= S_WR;
                        else
                            r_state <= S_RD;
                    end
                end
                S_RD: begin
                    r_hold  <= mem_read_data;
                    r_state <= r_write ? S_WR : S_RESP;
                end
                S_WR:   r_state <= S_RESP;
                S_RESP: r_state <= S_IDLE;
            endcase
        end
    end

    mem_lane_align u_align (
        .i_hold    (r_hold),
        .i_wdata   (r_wdata),
        .i_off     (r_off),
        .i_size    (r_size),
        .i_signed  (r_signed),
        .o_ld_data (w_ld_data),
        .o_st_data (w_st_data)
    );

    // Outputs depend only on registered state; rst_n gates ready during reset.
    assign req_ready      = rst_n && (r_state == S_IDLE);
    assign mem_read       = (r_state == S_RD);
    assign mem_write      = (r_state == S_WR);
    assign mem_address    = r_addr;
    assign mem_write_data = mem_write ? w_st_data : '0;
    assign rsp_valid      = (r_state == S_RESP);
    assign rsp_fault      = rsp_valid && r_fault;
    assign rsp_rdata      = (rsp_valid && !r_write && !r_fault) ? w_ld_data : '0;

endmodule
